cdc_rst_seq: RTL
================

Name: cdc_rst_seq

Overview:
- Reset release sequencer in the destination clock domain.
- Consumes the synchronized reset produced by the reset synchronizer stage and drives NUM_OUT downstream reset outputs.
- Holds all outputs in reset for a minimum pulse width, then releases them one at a time in index order 0..NUM_OUT-1. Each release waits for a per-stage ready/ack before the next begins.
- Supports a software-requested re-sequence and flags a stage that never reports ready.

Parameters:
NUM_OUT, 4, number of sequenced reset outputs (min 1)
MIN_ASSERT, 8, cycles all outputs stay asserted after i_rst deasserts (min 1)
STAGE_DLY, 16, cycles between entering a stage and releasing its reset (min 1)
TIMEOUT, 64, max cycles to wait for i_ready[idx] after release (min 1)

Ports:
clk  input  1  clock, destination domain
i_rst  input  1  reset, synchronous, active-high (driven by synchronizer output)
i_ready  input  NUM_OUT  per-stage ready/ack; bit k valid only after o_rst[k] released
i_soft_rst_req  input  1  single-cycle request to re-run the full sequence
o_rst  output  NUM_OUT  sequenced active-high resets, registered
o_done  output  1  high while every stage is released and ready
o_soft_rst_ack  output  1  one-cycle pulse when a soft request is accepted
o_err  output  1  sticky timeout flag
o_err_stage  output  max(1,$clog2(NUM_OUT))  index of the stage that timed out

Behaviour:
- All outputs are registered. Reset values: o_rst all 1, o_done 0, o_soft_rst_ack 0, o_err 0, o_err_stage 0. Internal: state ASSERT, idx 0, cnt 0.
- i_rst dominates everything, including a soft request, in any state. At the first edge it is sampled high, the reset values apply.
- Cycle numbering: cycle 0 is the first cycle i_rst is sampled low.
- FSM states: ASSERT, DELAY, WAIT_RDY, DONE, ERROR.
- ASSERT: cnt increments each cycle. When cnt==MIN_ASSERT-1: go to DELAY, idx=0, cnt=0.
- DELAY: cnt increments. When cnt==STAGE_DLY-1: clear o_rst[idx] and go to WAIT_RDY with cnt=0. o_rst[idx] reads low in the first WAIT_RDY cycle.
- WAIT_RDY:
  - If i_ready[idx]==1 and idx==NUM_OUT-1: go to DONE, o_done=1.
  - If i_ready[idx]==1 and idx<NUM_OUT-1: idx++, cnt=0, go to DELAY.
  - If i_ready[idx]==0: cnt increments. When cnt==TIMEOUT-1 with ready still low: go to ERROR, o_err=1, o_err_stage=idx, all o_rst=1 (safe state).
- Release timing with defaults and i_ready always high: o_rst[k] falls at cycle 24+17k (24, 41, 58, 75). o_done rises at cycle 76.
- DONE: o_rst all 0 and o_done=1. i_ready is not monitored; a later drop of i_ready has no effect.
- Soft request:
  - Accepted only in DONE or ERROR. On acceptance, next cycle: all o_rst=1, o_done=0, o_err=0, o_err_stage=0, o_soft_rst_ack=1 for one cycle, state ASSERT, cnt=0, idx=0.
  - Ignored silently in ASSERT, DELAY and WAIT_RDY; no ack.
- ERROR: holds until i_rst or an accepted soft request. o_err stays high.
- Released stages are never re-asserted individually. Re-assertion is always all outputs at once.
- Width rules:
  - cnt width = $clog2(max(MIN_ASSERT, STAGE_DLY, TIMEOUT)+1). cnt never wraps, since every compare exits before overflow.
  - idx width matches o_err_stage.
- NUM_OUT=1: idx is fixed at 0; the sequence reduces to ASSERT → DELAY → WAIT_RDY → DONE.
- i_rst pulse mid-sequence (any state): immediate full reassert, then the sequence restarts from cycle 0 after deassert.

Decomposition:
- Shared package cdc_pkg: state enum type rst_seq_state_e {ASSERT, DELAY, WAIT_RDY, DONE, ERROR}; helper function for max of three ints used in counter sizing.
- No sub-module. The single counter and FSM fit in one module; the upstream reset synchronizer is instantiated by the parent, not inside this block.

Test Plan:
- Power-up, defaults, i_ready=4'hF, i_rst deasserted at cycle 0 -> o_rst bits fall at cycles 24/41/58/75, o_done=1 from cycle 76, o_err=0.
- i_ready[2] rises 5 cycles after o_rst[2] falls (cycle 58) -> transition to DELAY at cycle 64, o_rst[3] falls at cycle 80, o_done at 81.
- i_ready[1] held 0, TIMEOUT=64 -> o_rst[1] falls at 41, ERROR at cycle 105: o_err=1, o_err_stage=1, o_rst=4'hF; remains there until a soft request.
- In DONE, pulse i_soft_rst_req -> next cycle o_soft_rst_ack=1 (one cycle), o_rst=4'hF, o_done=0; full sequence repeats with the same offsets relative to the ack cycle.
- i_soft_rst_req pulsed during DELAY/WAIT_RDY -> no ack, sequence timing unchanged.
- i_rst asserted at cycle 50 (stage 1 released, stage 2 pending) -> o_rst=4'hF next edge. After deassert, the sequence restarts from cycle 0; o_err and o_done stay 0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the reset release sequencer.
//   rst_seq_state_e : sequencer FSM states
//   max3()          : largest of three values, used to size the shared counter
package cdc_pkg;

   typedef enum logic [2:0] {
      ASSERT   = 3'd0,
      DELAY    = 3'd1,
      WAIT_RDY = 3'd2,
      DONE     = 3'd3,
      ERROR    = 3'd4
   } rst_seq_state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/cdc_rst_seq.sv
// Reset release sequencer for the destination clock domain.
// Holds every downstream reset asserted for MIN_ASSERT cycles after i_rst drops, then releases
// the outputs one at a time in index order, each STAGE_DLY cycles after its stage begins, and
// waits for that stage's ready before moving on. A stage that stays not-ready for TIMEOUT cycles
// puts every output back into reset and raises a sticky error.
//
// Ports:
//   clk            : destination-domain clock
//   i_rst          : synchronous active-high reset (from the upstream synchronizer)
//   i_ready        : per-stage ready/ack, meaningful only once that stage is released
//   i_soft_rst_req : single-cycle request to re-run the sequence (honoured in DONE/ERROR)
//   o_rst          : sequenced active-high resets
//   o_done         : every stage released and acknowledged
//   o_soft_rst_ack : one-cycle pulse when a soft request is taken
//   o_err          : sticky timeout flag
//   o_err_stage    : index of the stage that timed out
module cdc_rst_seq
   import cdc_pkg::*;
#(
   parameter int unsigned NUM_OUT    = 4,
   parameter int unsigned MIN_ASSERT = 8,
   parameter int unsigned STAGE_DLY  = 16,
   parameter int unsigned TIMEOUT    = 64,
   localparam int unsigned IdxW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic [NUM_OUT-1:0]  i_ready,
   input  logic                i_soft_rst_req,
   output logic [NUM_OUT-1:0]  o_rst,
   output logic                o_done,
   output logic                o_soft_rst_ack,
   output logic                o_err,
   output logic [IdxW-1:0]     o_err_stage
);

   // One counter serves all three timed phases; each compare exits before it could wrap.
   localparam int unsigned CntW = $clog2(max3(MIN_ASSERT, STAGE_DLY, TIMEOUT) + 1);

   localparam logic [CntW-1:0] AssertLast  = CntW'(MIN_ASSERT - 1);
   localparam logic [CntW-1:0] DelayLast   = CntW'(STAGE_DLY - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
   localparam logic [IdxW-1:0] IdxLast     = IdxW'(NUM_OUT - 1);

   rst_seq_state_e     state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [IdxW-1:0]    idx_q, idx_d;
   logic [NUM_OUT-1:0] rst_q, rst_d;
   logic               done_q, done_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [IdxW-1:0]    err_stage_q, err_stage_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rst_d       = rst_q;
      done_d      = done_q;
      ack_d       = 1'b0;
      err_d       = err_q;
      err_stage_d = err_stage_q;

      case (state_q)
         ASSERT: begin
            if (cnt_q == AssertLast) begin
               state_d = DELAY;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         DELAY: begin
            if (cnt_q == DelayLast) begin
               rst_d[idx_q] = 1'b0;
               state_d      = WAIT_RDY;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         WAIT_RDY: begin
            if (i_ready[idx_q]) begin
               if (idx_q == IdxLast) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DELAY;
                  idx_d   = idx_q + IdxW'(1);
                  cnt_d   = '0;
               end
            end else if (cnt_q == TimeoutLast) begin
               // Stuck stage: put everything back into reset, not just the stalled stage.
               state_d     = ERROR;
               err_d       = 1'b1;
               err_stage_d = idx_q;
               rst_d       = '1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         DONE, ERROR: begin
            // i_ready is deliberately ignored here; only a soft request leaves.
            if (i_soft_rst_req) begin
               state_d     = ASSERT;
               cnt_d       = '0;
               idx_d       = '0;
               rst_d       = '1;
               done_d      = 1'b0;
               err_d       = 1'b0;
               err_stage_d = '0;
               ack_d       = 1'b1;
            end
         end

         default: begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q     <= ASSERT;
         cnt_q       <= '0;
         idx_q       <= '0;
         rst_q       <= '1;
         done_q      <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         err_stage_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rst_q       <= rst_d;
         done_q      <= done_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign o_rst          = rst_q;
   assign o_done         = done_q;
   assign o_soft_rst_ack = ack_q;
   assign o_err          = err_q;
   assign o_err_stage    = err_stage_q;

endmodule
